// File: rtl/hash_wfsm_if.sv
// hash_wfsm_if: write-side burst-master link used by hash_wfsm.
//
// Handshake: a beat on write_data moves when write_data_valid and
// bus_write_ready are both high on the same rising clk edge. Once the
// source raises write_data_valid it keeps write_data stable until that
// edge. bus_write_ready may change freely and does not depend on valid.
// init_master_txn is a one-cycle request; write_done is a one-cycle
// completion pulse from the master.
interface hash_wfsm_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32
);
    logic                  init_master_txn;
    logic [ADDR_WIDTH-1:0] write_addr_index;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_data_valid;
    logic                  bus_write_ready;
    logic                  write_done;

    // FSM side: issues the request and the beats
    modport master (
        output init_master_txn,
        output write_addr_index,
        output write_data,
        output write_data_valid,
        input  bus_write_ready,
        input  write_done
    );

    // Burst-master side: accepts beats and reports completion
    modport slave (
        input  init_master_txn,
        input  write_addr_index,
        input  write_data,
        input  write_data_valid,
        output bus_write_ready,
        output write_done
    );
endinterface

// File: rtl/hash_wfsm.sv
// hash_wfsm: writes a finished Keccak digest back to OCM as a single
// burst of HASH_WIDTH/DATA_WIDTH beats, beat 0 = least significant slice.
// Sequence: IDLE -> INIT (request pulse) -> STREAM (beats) -> WAIT_DONE
// -> DONE (done pulse) -> IDLE. The digest and base index are captured
// on start, so the producer may change them afterwards.
//
// Optional watchdog: define HASH_WFSM_TIMEOUT_EN to abort WAIT_DONE after
// TIMEOUT_CYCLES cycles without write_done, setting sticky timeout_err.
// Without the macro no counter exists and timeout_err is tied low.
module hash_wfsm #(
    parameter int DATA_WIDTH     = 128,
    parameter int HASH_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [HASH_WIDTH-1:0] keccak_hash_reg,
    input  logic [ADDR_WIDTH-1:0] dest_index,
    hash_wfsm_if.master           wr_bus,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [2:0]            state_dbg
);
    localparam int NUM_BEATS = HASH_WIDTH / DATA_WIDTH;
    localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

    // Reject configurations the beat slicing or watchdog cannot express
    if ((HASH_WIDTH % DATA_WIDTH) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("hash_wfsm: HASH_WIDTH must be a multiple of DATA_WIDTH and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_STREAM    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DONE      = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [HASH_WIDTH-1:0] shadow_q, shadow_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] beats [NUM_BEATS];

`ifdef HASH_WFSM_TIMEOUT_EN
    localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           err_q, err_d;
`endif

    // Split the shadow digest into beat-sized slices, beat 0 at the LSBs
    for (genvar g = 0; g < NUM_BEATS; g++) begin : g_beats
        assign beats[g] = shadow_q[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // State and datapath registers, synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            shadow_q   <= '0;
            addr_q     <= '0;
`ifdef HASH_WFSM_TIMEOUT_EN
            wd_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            shadow_q   <= shadow_d;
            addr_q     <= addr_d;
`ifdef HASH_WFSM_TIMEOUT_EN
            wd_cnt_q   <= wd_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // Next-state logic: capture, request, stream beats, await completion
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        shadow_d   = shadow_q;
        addr_d     = addr_q;
`ifdef HASH_WFSM_TIMEOUT_EN
        wd_cnt_d   = wd_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shadow_d   = keccak_hash_reg;
                    addr_d     = dest_index;
                    beat_cnt_d = '0;
                    state_d    = S_INIT;
`ifdef HASH_WFSM_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                end
            end
            S_INIT: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                // valid is always high here, so ready alone means acceptance
                if (wr_bus.bus_write_ready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        // write_done only counts on the last-beat cycle
                        state_d = wr_bus.write_done ? S_DONE : S_WAIT_DONE;
`ifdef HASH_WFSM_TIMEOUT_EN
                        wd_cnt_d = '0;
`endif
                    end
                end
            end
            S_WAIT_DONE: begin
                if (wr_bus.write_done) begin
                    state_d = S_DONE;
                end
`ifdef HASH_WFSM_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                addr_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state; data is zero off-stream
    assign wr_bus.init_master_txn  = (state_q == S_INIT);
    assign wr_bus.write_data_valid = (state_q == S_STREAM);
    assign wr_bus.write_data       = (state_q == S_STREAM) ? beats[beat_cnt_q] : '0;
    assign wr_bus.write_addr_index = addr_q;
    assign busy                    = (state_q != S_IDLE);
    assign done                    = (state_q == S_DONE);
    assign state_dbg               = state_q;

`ifdef HASH_WFSM_TIMEOUT_EN
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_hash_wfsm.sv
// tb_hash_wfsm: bench for hash_wfsm. Table of burst vectors plus
// hand-written reset, ignored-input and watchdog sequences.
module tb_hash_wfsm;
    localparam int DW = 128;
    localparam int HW = 512;
    localparam int AW = 32;
    localparam int TO = 8;
    localparam int NB = HW / DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [HW-1:0] keccak_hash_reg;
    logic [AW-1:0] dest_index;
    logic          busy, done, timeout_err;
    logic [2:0]    state_dbg;

    hash_wfsm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    hash_wfsm #(
        .DATA_WIDTH(DW), .HASH_WIDTH(HW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .keccak_hash_reg(keccak_hash_reg), .dest_index(dest_index),
        .wr_bus(bus_if), .busy(busy), .done(done),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [HW-1:0] hash;
        logic [AW-1:0] dest;
        logic [7:0]    rdy_pat;   // ready per stream cycle, LSB first
        int            rdy_len;
        int            wd_delay;  // cycles after last beat for write_done
        bit            restart;   // extra start + early write_done at cycle 3
        int            exp_done;  // cycle of done relative to start
    } vec_t;

    vec_t          vecs [5];
    logic [DW-1:0] exp_q [$];
    int            checks = 0;
    int            errors = 0;
    int            inits_seen = 0, dones_seen = 0;
    int            exp_inits = 0, exp_dones = 0;
    bit            hold_valid = 1'b0;
    logic [DW-1:0] hold_data = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard/monitor, run mid-cycle on the falling edge
    task automatic monitor();
        logic [DW-1:0] e;
        if (bus_if.init_master_txn) inits_seen++;
        if (done) dones_seen++;
        if (bus_if.write_data_valid) begin
            if (hold_valid) begin
                checks++;
                if (bus_if.write_data !== hold_data) begin
                    errors++;
                    $display("FAIL data_stable: got %h expected %h", bus_if.write_data, hold_data);
                end
            end
            if (bus_if.bus_write_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got %h expected no beat", bus_if.write_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_if.write_data !== e) begin
                        errors++;
                        $display("FAIL beat_data: got %h expected %h", bus_if.write_data, e);
                    end
                end
            end
            hold_valid = !bus_if.bus_write_ready;
            hold_data  = bus_if.write_data;
        end else begin
            hold_valid = 1'b0;
        end
    endtask

    // Advance one cycle; inputs are then driven 1 time unit after posedge
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic [HW-1:0] h);
        for (int b = 0; b < NB; b++) exp_q.push_back(h[b*DW +: DW]);
        exp_inits++;
    endtask

    // Driver: one complete transaction from a table record
    task automatic run_vec(input vec_t v, input string name);
        int acc, last_c;
        bit seen_done;
        keccak_hash_reg = v.hash;
        dest_index      = v.dest;
        start           = 1'b1;
        bus_if.bus_write_ready = 1'b0;
        bus_if.write_done      = 1'b0;
        push_beats(v.hash);
        exp_dones++;
        acc = 0; last_c = -1; seen_done = 1'b0;
        for (int c = 1; c <= 60 && !seen_done; c++) begin
            step();
            start           = v.restart && (c == 3);
            keccak_hash_reg = ~v.hash;
            dest_index      = ~v.dest;
            bus_if.bus_write_ready = (c >= 2) ? v.rdy_pat[(c - 2) % v.rdy_len] : 1'b0;
            chk({name, "_init"}, 64'(bus_if.init_master_txn), 64'(c == 1));
            if (c == 1) chk({name, "_err_clear"}, 64'(timeout_err), 64'd0);
            if (busy && !done) chk({name, "_addr"}, 64'(bus_if.write_addr_index), 64'(v.dest));
            if (bus_if.write_data_valid && bus_if.bus_write_ready) begin
                acc++;
                if (acc == NB) last_c = c;
            end
            bus_if.write_done = (last_c >= 0 && c == last_c + v.wd_delay) ||
                                (v.restart && c == 3);
            if (done) begin
                seen_done = 1'b1;
                chk({name, "_done_cycle"}, 64'(c), 64'(v.exp_done));
            end
        end
        if (!seen_done) chk({name, "_done_seen"}, 64'd0, 64'd1);
        bus_if.write_done      = 1'b0;
        bus_if.bus_write_ready = 1'b0;
        step();
        chk({name, "_idle_busy"}, 64'(busy), 64'd0);
        chk({name, "_idle_addr"}, 64'(bus_if.write_addr_index), 64'd0);
        chk({name, "_idle_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [HW-1:0] h;

        // Vector table; done cycles worked out from ready pattern and delay
        vecs[0] = '{hash: {128'h3, 128'h2, 128'h1, 128'h0}, dest: 32'h40,
                    rdy_pat: 8'b1, rdy_len: 1, wd_delay: 0, restart: 1'b0, exp_done: 6};
        for (int w = 0; w < HW / 32; w++) h[w*32 +: 32] = $urandom;
        vecs[1] = '{hash: h, dest: 32'h1234_5678,
                    rdy_pat: 8'b001, rdy_len: 3, wd_delay: 0, restart: 1'b1, exp_done: 12};
        for (int w = 0; w < HW / 32; w++) h[w*32 +: 32] = $urandom;
        vecs[2] = '{hash: h, dest: 32'hFFFF_FFFC,
                    rdy_pat: 8'b1, rdy_len: 1, wd_delay: 3, restart: 1'b0, exp_done: 9};
        for (int w = 0; w < HW / 32; w++) h[w*32 +: 32] = $urandom;
        vecs[3] = '{hash: h, dest: 32'h0000_0A00,
                    rdy_pat: 8'b0110, rdy_len: 4, wd_delay: 1, restart: 1'b0, exp_done: 10};
        vecs[4] = '{hash: {HW{1'b1}}, dest: 32'h0,
                    rdy_pat: 8'b10, rdy_len: 2, wd_delay: 0, restart: 1'b0, exp_done: 10};

        // Reset
        reset = 1'b1; start = 1'b0; keccak_hash_reg = '0; dest_index = '0;
        bus_if.bus_write_ready = 1'b0; bus_if.write_done = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_state", 64'(state_dbg), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_init", 64'(bus_if.init_master_txn), 64'd0);
        chk("rst_valid", 64'(bus_if.write_data_valid), 64'd0);
        chk("rst_addr", 64'(bus_if.write_addr_index), 64'd0);
        chk("rst_data", bus_if.write_data[63:0], 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(timeout_err), 64'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during beat 2 aborts without done
        for (int w = 0; w < HW / 32; w++) h[w*32 +: 32] = $urandom;
        keccak_hash_reg = h; dest_index = 32'h80; start = 1'b1;
        push_beats(h);
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
            bus_if.bus_write_ready = (c >= 2);
        end
        step();
        bus_if.bus_write_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_state", 64'(state_dbg), 64'd0);
        chk("midrst_init", 64'(bus_if.init_master_txn), 64'd0);
        chk("midrst_valid", 64'(bus_if.write_data_valid), 64'd0);
        chk("midrst_data", bus_if.write_data[63:0], 64'd0);
        chk("midrst_addr", 64'(bus_if.write_addr_index), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        run_vec(vecs[0], "post_rst");

`ifdef HASH_WFSM_TIMEOUT_EN
        // Watchdog: no write_done, abort 8 cycles after entering WAIT_DONE
        for (int w = 0; w < HW / 32; w++) h[w*32 +: 32] = $urandom;
        keccak_hash_reg = h; dest_index = 32'hC0; start = 1'b1;
        push_beats(h);
        for (int c = 1; c <= 14; c++) begin
            step();
            start = 1'b0;
            bus_if.bus_write_ready = 1'b1;
            if (c == 13) begin
                chk("wd_err_before", 64'(timeout_err), 64'd0);
                chk("wd_busy_before", 64'(busy), 64'd1);
            end
        end
        bus_if.bus_write_ready = 1'b0;
        chk("wd_err_set", 64'(timeout_err), 64'd1);
        chk("wd_idle", 64'(state_dbg), 64'd0);
        chk("wd_no_done", 64'(done), 64'd0);
        repeat (2) step();
        chk("wd_err_sticky", 64'(timeout_err), 64'd1);
        run_vec(vecs[2], "after_wd");
`endif

        step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("init_count", 64'(inits_seen), 64'(exp_inits));
        chk("done_count", 64'(dones_seen), 64'(exp_dones));
        chk("final_err", 64'(timeout_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit in case the DUT stalls a wait in an unexpected way
    initial begin
        #200000;
        $display("FAIL time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/hash_wfsm.md
Name: hash_wfsm

Overview:
- Write-side counterpart of the SHA3 read/absorb FSM. Takes the finished 512-bit Keccak digest and writes it back to OCM through the burst master as one 4-beat write burst of 128 bits per beat.
- Captures the hash on a start pulse and requests the transaction. Streams beats under a valid/ready handshake, waits for burst completion, then reports done.

Parameters:
- DATA_WIDTH, 128, bus beat width in bits.
- HASH_WIDTH, 512, digest width; must be a multiple of DATA_WIDTH.
- ADDR_WIDTH, 32, width of the write address index.
- TIMEOUT_CYCLES, 1024, WAIT_DONE watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: digest valid, begin write-back.
- keccak_hash_reg  in  HASH_WIDTH  digest to write.
- dest_index  in  ADDR_WIDTH  OCM base index for the burst.
- init_master_txn  out  1  one-cycle pulse requesting a burst-master write transaction.
- write_addr_index  out  ADDR_WIDTH  burst base index, held for the whole transaction.
- write_data  out  DATA_WIDTH  current beat data.
- write_data_valid  out  1  write_data is valid.
- bus_write_ready  in  1  master accepts the beat this cycle.
- write_done  in  1  master reports burst completion (pulse).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when write-back completes.
- timeout_err  out  1  sticky watchdog error flag; tied 0 without the optional feature.

Behaviour:
- Reset: state = IDLE. All outputs 0, shadow hash 0, beat_cnt 0, watchdog counter 0. Reset mid-transaction aborts immediately; no done pulse is generated.
- NUM_BEATS = HASH_WIDTH/DATA_WIDTH (4). beat_cnt is clog2(NUM_BEATS) bits wide.
- IDLE:
  - On start: latch keccak_hash_reg into the shadow register and dest_index into write_addr_index; beat_cnt = 0; go to INIT.
  - Input changes after the capture cycle have no effect.
- INIT: init_master_txn = 1 for exactly this cycle; go to STREAM.
- STREAM:
  - write_data_valid = 1 and write_data = shadow[beat_cnt*DATA_WIDTH +: DATA_WIDTH]. Beat 0 is the least significant 128 bits.
  - A beat is accepted when write_data_valid && bus_write_ready; beat_cnt then increments. write_data must stay stable until the beat is accepted.
  - On acceptance of the last beat: write_data_valid falls the next cycle and the state goes to WAIT_DONE.
  - If write_done is also high in that same cycle, go directly to DONE.
- WAIT_DONE: write_data_valid = 0. On write_done, go to DONE.
- DONE: done = 1 for one cycle; write_addr_index is cleared; go to IDLE.
- write_done is ignored in IDLE and INIT, and ignored in STREAM except on the last-beat cycle.
- start is ignored while busy = 1; there is no queuing.
- Latency, with ready tied high: start at cycle 0 → init_master_txn at cycle 1 → beats at cycles 2–5 → earliest done at cycle 6 (write_done at cycle 5).
- busy is registered and reflects the current state.

Optional Feature:
- Macro: HASH_WFSM_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DONE. On reaching TIMEOUT_CYCLES without write_done, the block sets timeout_err, returns to IDLE and does not pulse done.
  - timeout_err stays set until reset or the next accepted start.
  - The counter clears on entry to WAIT_DONE.
- Undefined: no counter is built; timeout_err is tied 0; WAIT_DONE waits indefinitely.

Test Plan:
- Basic burst:
  - Stimulus: hash = {128'h3,128'h2,128'h1,128'h0}, dest_index = 32'h40, ready held 1, write_done at cycle 5.
  - Required: one init pulse at cycle 1; write_data 0,1,2,3 on cycles 2–5; write_addr_index = 32'h40 throughout; done at cycle 6.
- Backpressure:
  - Stimulus: bus_write_ready toggles 1,0,0,1,...
  - Required: write_data holds its value while ready = 0; exactly 4 beats accepted, in order; no beat duplicated or skipped.
- Ignored inputs:
  - Stimulus: second start pulse during STREAM; keccak_hash_reg changed after capture; early write_done during beat 1.
  - Required: no second init_master_txn; data written is the originally captured hash; state does not exit STREAM early.
- Same-cycle completion: write_done coincident with the last beat acceptance → DONE next cycle, WAIT_DONE skipped.
- Reset mid-operation: reset asserted during beat 2 → next cycle all outputs 0, busy = 0, no done pulse; a new start then runs a full, correct burst.
- Watchdog (macro defined), TIMEOUT_CYCLES = 8, no write_done:
  - Required: timeout_err = 1 eight cycles after entering WAIT_DONE; state returns to IDLE; done stays 0.
  - Required: the next start clears timeout_err.
